// File: rtl/l1_req_queue.sv
// In-order request queue in front of the L1 data cache: buffers CPU loads/stores,
// issues them one at a time to the cache and returns each response in push order.
module l1_req_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // CPU request side
    input  logic                       cpu_req_valid,
    output logic                       cpu_req_ready,
    input  logic                       cpu_req_we,
    input  logic [31:0]                cpu_req_addr,
    input  logic [31:0]                cpu_req_wdata,
    input  logic [3:0]                 cpu_req_wstrb,
    // CPU response side
    output logic                       cpu_resp_valid,
    output logic                       cpu_resp_we,
    output logic [31:0]                cpu_resp_rdata,
    // Cache request port
    output logic                       cache_req_valid,
    output logic                       cache_req_we,
    output logic [31:0]                cache_req_addr,
    output logic [31:0]                cache_req_wdata,
    output logic [3:0]                 cache_req_wstrb,
    // Cache response port
    input  logic                       cache_resp_valid,
    input  logic [31:0]                cache_resp_rdata,
    input  logic                       cache_resp_stall,
    // Status
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       timeout_err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt    = CntW'(DEPTH);
    localparam logic [15:0]     TimeoutVal = 16'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [15:0]     wait_q, wait_d;
    logic            timeout_q, timeout_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_we_q, resp_we_d;

    logic            push;
    logic            pop;
    logic [15:0]     wait_inc;
    entry_t          head;

    // Stall is purely informational; the FSM just waits in StReq for resp_valid.
    logic unused_stall;
    assign unused_stall = cache_resp_stall;

    // No pop bypass: a full queue rejects even on the cycle it pops.
    assign cpu_req_ready = (count_q != FullCnt);
    assign push          = cpu_req_valid && cpu_req_ready;
    assign pop           = (state_q == StReq) && cache_resp_valid;
    assign head          = mem_q[rd_ptr_q];

    // FIFO storage, pointers and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{we:    cpu_req_we,
                                addr:  cpu_req_addr,
                                wdata: cpu_req_wdata,
                                wstrb: cpu_req_wstrb};
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue FSM, wait counter and response capture
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        resp_rdata_d = resp_rdata_q;
        resp_we_d    = resp_we_q;
        wait_inc     = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                wait_d = wait_inc;
                if (wait_inc == TimeoutVal) begin
                    timeout_d = 1'b1;
                end
                if (cache_resp_valid) begin
                    wait_d       = '0;
                    resp_we_d    = head.we;
                    resp_rdata_d = head.we ? 32'd0 : cache_resp_rdata;
                    state_d      = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= StIdle;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
            resp_rdata_q <= '0;
            resp_we_q    <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
            resp_rdata_q <= resp_rdata_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // Request fields are zeroed outside StReq so idle/reset outputs read as 0.
    always_comb begin
        cache_req_valid = (state_q == StReq);
        cache_req_we    = 1'b0;
        cache_req_addr  = '0;
        cache_req_wdata = '0;
        cache_req_wstrb = '0;
        if (cache_req_valid) begin
            cache_req_we    = head.we;
            cache_req_addr  = head.addr;
            cache_req_wdata = head.wdata;
            cache_req_wstrb = head.wstrb;
        end
    end

    always_comb begin
        cpu_resp_valid = (state_q == StResp);
        cpu_resp_we    = 1'b0;
        cpu_resp_rdata = '0;
        if (cpu_resp_valid) begin
            cpu_resp_we    = resp_we_q;
            cpu_resp_rdata = resp_rdata_q;
        end
    end

    assign occupancy   = count_q;
    assign timeout_err = timeout_q;

endmodule
